// File: rtl/bike_pkg.sv
// bike_pkg: shared widths, limits and the saturating HH:MM:SS increment for the trip recorder.
package bike_pkg;
    localparam int HOUR_W      = 7;
    localparam int MIN_W       = 6;
    localparam int SEC_W       = 6;
    localparam int HMS_W       = HOUR_W + MIN_W + SEC_W;
    localparam int DIST_W      = 14;
    localparam int SPEED_W     = 7;
    localparam int DIST_MAX    = 9999;
    localparam int CM_PER_UNIT = 10000;
    localparam int HOURS_MAX   = 99;

    typedef struct packed {
        logic [HOUR_W-1:0] h;
        logic [MIN_W-1:0]  m;
        logic [SEC_W-1:0]  s;
    } hms_t;

    // Holds at HOURS_MAX:59:59; the carry out of the hours field is dropped.
    function automatic logic [HMS_W-1:0] hms_inc(input logic [HMS_W-1:0] v);
        hms_t t;
        hms_t r;
        t = v;
        r = t;
        if (t.s != SEC_W'(59)) r.s = t.s + SEC_W'(1);
        else if (t.m != MIN_W'(59)) begin
            r.s = '0;
            r.m = t.m + MIN_W'(1);
        end else if (t.h != HOUR_W'(HOURS_MAX)) begin
            r   = '0;
            r.h = t.h + HOUR_W'(1);
        end
        return r;
    endfunction
endpackage

// File: rtl/reed_sync.sv
// reed_sync: two-flop synchronizer for the raw reed switch plus rising-edge detect (one-cycle rev).
module reed_sync (
    input  logic clock,
    input  logic reset,
    input  logic reed_i,
    output logic rev_o
);
    logic [2:0] sh_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) sh_q <= '0;
        else sh_q <= {sh_q[1:0], reed_i};
    end

    assign rev_o = sh_q[1] & ~sh_q[2];
endmodule

// File: rtl/trip_recorder.sv
// trip_recorder: timebase pulses, trip distance, max speed and saturating HH:MM:SS trip timer.
// Define TRIP_AUTO_PAUSE_EN to pause the timer and drop moving after IDLE_SEC seconds without a rev.
module trip_recorder
    import bike_pkg::*;
#(
    parameter int CLK_HZ   = 2048,
    parameter int CIRC_CM  = 213,
    parameter int IDLE_SEC = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               reed,
    input  logic               trip_clear,
    input  logic [SPEED_W-1:0] speed,
    input  logic               speed_valid,
    output logic               half_sec_pulse,
    output logic               sec_pulse,
    output logic [DIST_W-1:0]  distance,
    output logic [SPEED_W-1:0] max_speed,
    output logic [HMS_W-1:0]   HMS_time,
    output logic               moving
);
    localparam int HALF = CLK_HZ / 2;
    localparam int PW   = $clog2(HALF);

    if (CLK_HZ < 4 || CLK_HZ % 2 != 0 || CIRC_CM < 1 || CIRC_CM > 1023 || IDLE_SEC < 1) begin : g_bad_cfg
        $error("trip_recorder: illegal parameter set");
    end

    logic [PW-1:0]      pre_q, pre_d;
    logic               phase_q, phase_d, half_q, sec_q;
    logic [DIST_W-1:0]  cm_q, cm_d, dist_q, dist_d, cm_sum;
    logic [SPEED_W-1:0] max_q, max_d;
    logic [HMS_W-1:0]   hms_q, hms_d;
    logic               mov_q, mov_d;
    logic               rev, wrap, tick, carry, run;

    reed_sync u_reed_sync (
        .clock (clock),
        .reset (reset),
        .reed_i(reed),
        .rev_o (rev)
    );

    // The timer advances on the same edge that raises sec_pulse, so seconds and pulse line up.
    always_comb begin
        wrap    = pre_q == PW'(HALF - 1);
        tick    = wrap & phase_q;
        pre_d   = wrap ? '0 : pre_q + PW'(1);
        phase_d = phase_q ^ wrap;
        cm_sum  = cm_q + DIST_W'(CIRC_CM);
        carry   = rev && cm_sum >= DIST_W'(CM_PER_UNIT);
        cm_d    = trip_clear ? '0 : carry ? cm_sum - DIST_W'(CM_PER_UNIT) : rev ? cm_sum : cm_q;
        dist_d  = trip_clear ? '0 : !carry ? dist_q : dist_q == DIST_W'(DIST_MAX) ? '0 : dist_q + DIST_W'(1);
        max_d   = trip_clear ? '0 : (speed_valid && speed > max_q) ? speed : max_q;
        hms_d   = trip_clear ? '0 : (tick && run) ? hms_inc(hms_q) : hms_q;
    end

`ifdef TRIP_AUTO_PAUSE_EN
    localparam int IW = $clog2(IDLE_SEC + 1);
    logic [IW-1:0] idle_q, idle_d;

    assign idle_d = (trip_clear | rev) ? '0 : (tick && idle_q != IW'(IDLE_SEC)) ? idle_q + IW'(1) : idle_q;
    assign mov_d  = trip_clear ? 1'b0 : rev ? 1'b1 : (idle_d == IW'(IDLE_SEC)) ? 1'b0 : mov_q;
    assign run    = mov_q | rev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) idle_q <= '0;
        else idle_q <= idle_d;
    end
`else
    assign mov_d = trip_clear ? 1'b0 : (mov_q | rev);
    assign run   = 1'b1;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre_q   <= '0;
            phase_q <= 1'b0;
            half_q  <= 1'b0;
            sec_q   <= 1'b0;
            cm_q    <= '0;
            dist_q  <= '0;
            max_q   <= '0;
            hms_q   <= '0;
            mov_q   <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            phase_q <= phase_d;
            half_q  <= wrap;
            sec_q   <= tick;
            cm_q    <= cm_d;
            dist_q  <= dist_d;
            max_q   <= max_d;
            hms_q   <= hms_d;
            mov_q   <= mov_d;
        end
    end

    assign half_sec_pulse = half_q;
    assign sec_pulse      = sec_q;
    assign distance       = dist_q;
    assign max_speed      = max_q;
    assign HMS_time       = hms_q;
    assign moving         = mov_q;
endmodule

// File: tb/tb_trip_recorder.sv
// tb_trip_recorder: directed plus randomized stimulus against a cycle-count / total-cm / total-seconds model.
module tb_trip_recorder;
    logic        clk = 1'b0, rst = 1'b1, reed = 1'b0, trip_clear = 1'b0, speed_valid = 1'b0;
    logic [6:0]  speed = '0;
    logic        half_sec_pulse, sec_pulse, moving;
    logic [13:0] distance;
    logic [6:0]  max_speed;
    logic [18:0] HMS_time;
    int          tests = 0, fails = 0;
    logic [13:0] f_dist;
    logic [18:0] f_hms;
    bit          hold = 0;

    int unsigned n = 0;
    longint      tot_cm = 0;
    int          secs = 0, mx = 0, idle = 0;
    bit          mov = 0;
    bit [2:0]    rh = '0;

    trip_recorder #(.CLK_HZ(8), .CIRC_CM(213), .IDLE_SEC(3)) dut (
        .clock         (clk),
        .reset         (rst),
        .reed          (reed),
        .trip_clear    (trip_clear),
        .speed         (speed),
        .speed_valid   (speed_valid),
        .half_sec_pulse(half_sec_pulse),
        .sec_pulse     (sec_pulse),
        .distance      (distance),
        .max_speed     (max_speed),
        .HMS_time      (HMS_time),
        .moving        (moving)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [18:0] hms_of(input int t);
        return {7'(t / 3600), 6'((t / 60) % 60), 6'(t % 60)};
    endfunction

    // Model: cycles since reset, total centimetres travelled, total elapsed seconds.
    always @(posedge clk) begin : model
        bit rev, tick, run;
        if (rst) begin
            n = 0; tot_cm = 0; secs = 0; mx = 0; mov = 0; rh = '0; idle = 0;
        end else begin
            n++;
            tick = (n % 8 == 0);
            rev  = rh[1] && !rh[2];
            rh   = {rh[1:0], reed};
`ifdef TRIP_AUTO_PAUSE_EN
            run = mov || rev;
            if (rev) idle = 0;
            else if (tick && idle < 3) idle++;
`else
            run = 1;
`endif
            if (trip_clear) begin
                tot_cm = 0; secs = 0; mx = 0; mov = 0; idle = 0;
            end else begin
                if (rev) tot_cm += 213;
                if (tick && run && !hold && secs < 359999) secs++;
                if (speed_valid && speed > mx) mx = speed;
`ifdef TRIP_AUTO_PAUSE_EN
                mov = rev ? 1 : (idle >= 3 ? 0 : mov);
`else
                mov = mov || rev;
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("half_sec_pulse", half_sec_pulse, n > 0 && n % 4 == 0);
            check("sec_pulse", sec_pulse, n > 0 && n % 8 == 0);
            check("distance", distance, (tot_cm / 10000) % 10000);
            check("max_speed", max_speed, mx);
            check("HMS_time", HMS_time, hms_of(secs));
            check("moving", moving, mov);
        end
    end

    task automatic edges(input int k);
        repeat (k) begin
            reed = 1'b1;
            repeat (2) @(negedge clk);
            reed = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic wait_sec();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!sec_pulse && k < 20);
        if (!sec_pulse) begin
            tests++;
            fails++;
            $display("FAIL wait_sec: sec_pulse got 0 expected 1 within 20 cycles");
        end
    endtask

    task automatic preload(input bit do_dist, input int t);
        #2;
        f_hms = hms_of(t);
        secs  = t;
        force dut.hms_q = f_hms;
        if (do_dist) begin
            f_dist = 14'd9999;
            tot_cm = 64'd99990000 + tot_cm % 10000;
            force dut.dist_q = f_dist;
        end
        hold = 1;
        @(posedge clk);
        @(negedge clk);
        #2;
        release dut.hms_q;
        if (do_dist) release dut.dist_q;
        hold = 0;
    endtask

    initial begin
        int hcnt, scnt, first;
        logic [6:0] sp [4];
        logic [6:0] me [4];
        sp = '{7'd30, 7'd65, 7'd40, 7'd65};
        me = '{7'd30, 7'd65, 7'd65, 7'd65};
        repeat (2) @(negedge clk);
        check("reset_outputs", {half_sec_pulse, sec_pulse, distance, max_speed, HMS_time, moving}, 0);
        #2 rst = 1'b0;
        hcnt = 0; scnt = 0; first = 0;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            hcnt += int'(half_sec_pulse);
            scnt += int'(sec_pulse);
            if (sec_pulse && first == 0) first = i;
        end
        check("half_count_32", hcnt, 8);
        check("sec_count_32", scnt, 4);
        check("first_sec_clock", first, 8);
        check("hms_after_32", HMS_time, 4);

        edges(47);
        repeat (4) @(negedge clk);
        check("dist_47_edges", distance, 1);
        check("cm_47_edges", dut.cm_q, 11);
        check("moving_after_edges", moving, 1);

        for (int i = 0; i < 4; i++) begin
            speed = sp[i];
            speed_valid = 1'b1;
            @(negedge clk);
            speed_valid = 1'b0;
            check("max_speed_seq", max_speed, me[i]);
        end
        trip_clear = 1'b1;
        @(negedge clk);
        trip_clear = 1'b0;
        check("max_after_clear", max_speed, 0);
        check("dist_after_clear", distance, 0);
        check("hms_after_clear", HMS_time, 0);

        preload(1, secs);
        edges(47);
        repeat (4) @(negedge clk);
        check("dist_wrap", distance, 0);
        check("cm_wrap", dut.cm_q, 11);

        wait_sec(); preload(0, 59);     wait_sec(); check("hms_00_01_00", HMS_time, 64);
        wait_sec(); preload(0, 3599);   wait_sec(); check("hms_01_00_00", HMS_time, 4096);
        wait_sec(); preload(0, 359999); wait_sec(); check("hms_sat", HMS_time, 409339);
        wait_sec(); check("hms_sat_hold", HMS_time, 409339);

        wait_sec();
        repeat (5) @(negedge clk);
        reed = 1'b1;
        repeat (2) @(negedge clk);
        trip_clear = 1'b1;
        @(negedge clk);
        trip_clear = 1'b0;
        reed = 1'b0;
        check("collide_dist", distance, 0);
        check("collide_cm", dut.cm_q, 0);
        check("collide_hms", HMS_time, 0);
        check("collide_moving", moving, 0);
        check("collide_sec_pulse", sec_pulse, 1);
        repeat (8) @(negedge clk);
        check("phase_kept_sec", sec_pulse, 1);
        check("phase_kept_hms", HMS_time, 1);

        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 2) == 0) reed = ~reed;
            speed_valid = $urandom_range(0, 3) == 0;
            speed = 7'($urandom_range(0, 127));
            trip_clear = $urandom_range(0, 299) == 0;
        end
        @(negedge clk);
        trip_clear = 1'b0;
        speed_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check("async_reset_outputs", {half_sec_pulse, sec_pulse, distance, max_speed, HMS_time, moving}, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 2) == 0) reed = ~reed;
            speed_valid = $urandom_range(0, 3) == 0;
            speed = 7'($urandom_range(0, 127));
        end
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
